// File: rtl/hamm_4096x1_checker.sv
// Compares computed vs stored sector ECC, classifies the sector and reports the faulty bit location.
// Latency: result 2 cycles after last operand capture; result held until result_ready_i, stored ECC stalled meanwhile.
module hamm_4096x1_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             calc_valid_i,
  input  logic             calc_eof_i,
  input  logic [23:0]      calc_ecc_i,
  input  logic             stored_valid_i,
  output logic             stored_ready_o,
  input  logic [23:0]      stored_ecc_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [2:0]       status_o,
  output logic [6:0]       err_word_o,
  output logic [4:0]       err_bit_o,
  output logic [23:0]      syndrome_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o,
  output logic             overrun_o
);

  typedef enum logic [2:0] {IDLE, HAVE_CALC, HAVE_STORED, EVAL, REPORT} state_t;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_CORR    = 3'd1;
  localparam logic [2:0] ST_ECC_ERR = 3'd2;
  localparam logic [2:0] ST_UNCORR  = 3'd3;
  localparam logic [2:0] ST_ERASED  = 3'd4;

  state_t      state;
  logic        calc_flag;
  logic        stored_flag;
  logic [23:0] calc_q;
  logic [23:0] stored_q;

  logic        calc_beat;
  logic        calc_busy;
  logic        calc_take;
  logic        calc_drop;
  logic        stored_take;
  logic        accept;

  logic [23:0] syn;
  logic [4:0]  syn_pop;
  logic [2:0]  status_nxt;

  assign calc_beat   = calc_valid_i & calc_eof_i;
  assign calc_busy   = calc_flag | (state == EVAL) | (state == REPORT);
  assign calc_take   = calc_beat & ~calc_busy;
  assign calc_drop   = calc_beat & calc_busy;
  assign stored_take = stored_valid_i & stored_ready_o;
  assign accept      = result_valid_o & result_ready_i;

  always_comb begin
    syn     = calc_q ^ stored_q;
    syn_pop = '0;
    for (int i = 0; i < 24; i++) begin
      syn_pop = syn_pop + {4'd0, syn[i]};
    end
    if (stored_q == 24'hFFFFFF && calc_q == 24'h000000) begin
      status_nxt = ST_ERASED;
    end else if (syn == 24'h0) begin
      status_nxt = ST_OK;
    end else if ((syn[11:0] ^ syn[23:12]) == 12'hFFF) begin
      status_nxt = ST_CORR;
    end else if (syn_pop == 5'd1) begin
      status_nxt = ST_ECC_ERR;
    end else begin
      status_nxt = ST_UNCORR;
    end
  end

  // stored_ready_o is registered alongside the state so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      calc_flag      <= 1'b0;
      stored_flag    <= 1'b0;
      calc_q         <= '0;
      stored_q       <= '0;
      stored_ready_o <= 1'b0;
      result_valid_o <= 1'b0;
      status_o       <= '0;
      err_word_o     <= '0;
      err_bit_o      <= '0;
      syndrome_o     <= '0;
      corr_cnt_o     <= '0;
      uncorr_cnt_o   <= '0;
      overrun_o      <= 1'b0;
    end else begin
      if (calc_take) begin
        calc_q    <= calc_ecc_i;
        calc_flag <= 1'b1;
      end
      if (stored_take) begin
        stored_q    <= stored_ecc_i;
        stored_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (calc_take && stored_take) begin
            state          <= EVAL;
            stored_ready_o <= 1'b0;
          end else if (calc_take) begin
            state          <= HAVE_CALC;
            stored_ready_o <= 1'b1;
          end else if (stored_take) begin
            state          <= HAVE_STORED;
            stored_ready_o <= 1'b0;
          end else begin
            stored_ready_o <= 1'b1;
          end
        end
        HAVE_CALC: begin
          if (stored_take) begin
            state          <= EVAL;
            stored_ready_o <= 1'b0;
          end else begin
            stored_ready_o <= 1'b1;
          end
        end
        HAVE_STORED: begin
          stored_ready_o <= 1'b0;
          if (calc_take) begin
            state <= EVAL;
          end
        end
        EVAL: begin
          state          <= REPORT;
          stored_ready_o <= 1'b0;
          result_valid_o <= 1'b1;
          syndrome_o     <= syn;
          status_o       <= status_nxt;
          err_word_o     <= (status_nxt == ST_CORR) ? syn[23:17] : 7'd0;
          err_bit_o      <= (status_nxt == ST_CORR) ? syn[16:12] : 5'd0;
        end
        REPORT: begin
          if (accept) begin
            state          <= IDLE;
            stored_ready_o <= 1'b1;
            result_valid_o <= 1'b0;
            calc_flag      <= 1'b0;
            stored_flag    <= 1'b0;
          end else begin
            stored_ready_o <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          stored_ready_o <= 1'b0;
        end
      endcase

      if (clr_i) begin
        corr_cnt_o   <= '0;
        uncorr_cnt_o <= '0;
        overrun_o    <= 1'b0;
      end else begin
        if (calc_drop) begin
          overrun_o <= 1'b1;
        end
        if (state == REPORT && accept) begin
          if (status_o == ST_CORR && corr_cnt_o != '1) begin
            corr_cnt_o <= corr_cnt_o + 1'b1;
          end
          if (status_o == ST_UNCORR && uncorr_cnt_o != '1) begin
            uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hamm_4096x1_checker.sv
// Directed, table-driven bench for hamm_4096x1_checker with hand-computed expectations.
module tb_hamm_4096x1_checker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             calc_valid_i = 1'b0;
  logic             calc_eof_i = 1'b0;
  logic [23:0]      calc_ecc_i = '0;
  logic             stored_valid_i = 1'b0;
  logic             stored_ready_o;
  logic [23:0]      stored_ecc_i = '0;
  logic             result_valid_o;
  logic             result_ready_i = 1'b0;
  logic [2:0]       status_o;
  logic [6:0]       err_word_o;
  logic [4:0]       err_bit_o;
  logic [23:0]      syndrome_o;
  logic             clr_i = 1'b0;
  logic [CNT_W-1:0] corr_cnt_o;
  logic [CNT_W-1:0] uncorr_cnt_o;
  logic             overrun_o;

  hamm_4096x1_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .calc_valid_i(calc_valid_i), .calc_eof_i(calc_eof_i), .calc_ecc_i(calc_ecc_i),
    .stored_valid_i(stored_valid_i), .stored_ready_o(stored_ready_o), .stored_ecc_i(stored_ecc_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .status_o(status_o), .err_word_o(err_word_o), .err_bit_o(err_bit_o), .syndrome_o(syndrome_o),
    .clr_i(clr_i), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] calc;
    logic [23:0] stored;
    logic [2:0]  st;
    logic [6:0]  word;
    logic [4:0]  bitn;
    logic [23:0] syn;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for result_valid_o; returns number of edges since the capture edge.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!result_valid_o && cyc < 8) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic accept_result(input logic [2:0] st, input logic with_clr);
    result_ready_i = 1'b1;
    clr_i = with_clr;
    step();
    result_ready_i = 1'b0;
    clr_i = 1'b0;
    if (with_clr) begin
      exp_corr = 0;
      exp_uncorr = 0;
    end else if (st == 3'd1) begin
      exp_corr++;
    end else if (st == 3'd3) begin
      exp_uncorr++;
    end
    @(negedge clk);
    check("valid_after_accept", {31'd0, result_valid_o}, 32'd0);
    check("corr_cnt", {16'd0, corr_cnt_o}, exp_corr);
    check("uncorr_cnt", {16'd0, uncorr_cnt_o}, exp_uncorr);
  endtask

  task automatic run_vec(input vec_t v, input logic with_clr);
    int cyc;
    step();
    calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = v.calc;
    stored_valid_i = 1'b1; stored_ecc_i = v.stored;
    step();
    calc_valid_i = 1'b0; calc_eof_i = 1'b0; stored_valid_i = 1'b0;
    wait_valid(cyc);
    check("latency", cyc, 2);
    check("status", {29'd0, status_o}, {29'd0, v.st});
    check("err_word", {25'd0, err_word_o}, {25'd0, v.word});
    check("err_bit", {27'd0, err_bit_o}, {27'd0, v.bitn});
    check("syndrome", {8'd0, syndrome_o}, {8'd0, v.syn});
    accept_result(v.st, with_clr);
  endtask

  initial begin
    int   cyc;
    logic stable;

    vecs[0] = '{24'h123456, 24'h180B0A, 3'd1, 7'd5,   5'd3,  24'h0A3F5C};
    vecs[1] = '{24'h000000, 24'h000400, 3'd2, 7'd0,   5'd0,  24'h000400};
    vecs[2] = '{24'h000000, 24'h000003, 3'd3, 7'd0,   5'd0,  24'h000003};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 3'd4, 7'd0,   5'd0,  24'hFFFFFF};
    vecs[4] = '{24'hABCDEF, 24'hABCDEF, 3'd0, 7'd0,   5'd0,  24'h000000};
    vecs[5] = '{24'h000000, 24'hFFF000, 3'd1, 7'd127, 5'd31, 24'hFFF000};
    vecs[6] = '{24'h000000, 24'h000FFF, 3'd1, 7'd0,   5'd0,  24'h000FFF};
    vecs[7] = '{24'h000000, 24'h800000, 3'd2, 7'd0,   5'd0,  24'h800000};
    vecs[8] = '{24'hFFFFFF, 24'h000000, 3'd3, 7'd0,   5'd0,  24'hFFFFFF};

    // Reset state
    #12;
    check("rst_ready", {31'd0, stored_ready_o}, 32'd0);
    check("rst_valid", {31'd0, result_valid_o}, 32'd0);
    check("rst_status", {29'd0, status_o}, 32'd0);
    check("rst_syndrome", {8'd0, syndrome_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    check("rst_cnts", {corr_cnt_o, uncorr_cnt_o}, 32'd0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("idle_ready", {31'd0, stored_ready_o}, 32'd1);

    // calc first, stored two cycles later
    step();
    calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = 24'h123456;
    step();
    calc_valid_i = 1'b0; calc_eof_i = 1'b0;
    step();
    check("have_calc_ready", {31'd0, stored_ready_o}, 32'd1);
    stored_valid_i = 1'b1; stored_ecc_i = 24'h123456;
    step();
    stored_valid_i = 1'b0;
    wait_valid(cyc);
    check("seq_latency", cyc, 2);
    check("seq_status", {29'd0, status_o}, 32'd0);
    check("seq_syndrome", {8'd0, syndrome_o}, 32'd0);
    accept_result(3'd0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // Stalled result with overrunning calc beat
    step();
    calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = 24'h123456;
    stored_valid_i = 1'b1; stored_ecc_i = 24'h180B0A;
    step();
    calc_valid_i = 1'b0; calc_eof_i = 1'b0; stored_valid_i = 1'b0;
    wait_valid(cyc);
    check("stall_latency", cyc, 2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = 24'h00FFFF;
      end
      @(posedge clk);
      #1;
      calc_valid_i = 1'b0; calc_eof_i = 1'b0;
      @(negedge clk);
      if (!result_valid_o || status_o != 3'd1 || err_word_o != 7'd5 || err_bit_o != 5'd3 ||
          syndrome_o != 24'h0A3F5C || stored_ready_o) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    check("stall_ready", {31'd0, stored_ready_o}, 32'd0);
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    accept_result(3'd1, 1'b0);
    step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    @(negedge clk);
    check("clr_overrun", {31'd0, overrun_o}, 32'd0);
    check("clr_corr", {16'd0, corr_cnt_o}, 32'd0);
    check("clr_uncorr", {16'd0, uncorr_cnt_o}, 32'd0);
    exp_corr = 0;
    exp_uncorr = 0;

    // clr_i wins over an accept-cycle increment
    run_vec(vecs[0], 1'b1);

    // Reset during HAVE_CALC discards the captured calc
    step();
    calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = 24'h00AAAA;
    step();
    calc_valid_i = 1'b0; calc_eof_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, stored_ready_o}, 32'd0);
    check("midrst_valid", {31'd0, result_valid_o}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    stored_valid_i = 1'b1; stored_ecc_i = 24'h555555;
    step();
    stored_valid_i = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result_valid_o || stored_ready_o) stable = 1'b0;
      step();
    end
    check("have_stored_wait", {31'd0, stable}, 32'd1);
    calc_valid_i = 1'b1; calc_eof_i = 1'b1; calc_ecc_i = 24'h555555;
    step();
    calc_valid_i = 1'b0; calc_eof_i = 1'b0;
    wait_valid(cyc);
    check("post_rst_latency", cyc, 2);
    check("post_rst_status", {29'd0, status_o}, 32'd0);
    check("post_rst_syndrome", {8'd0, syndrome_o}, 32'd0);
    accept_result(3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
